// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
// Holds the converter FSM encoding and the BCD accumulator geometry.
package bcd_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  localparam int          NUM_DIGITS = 4;
  localparam int unsigned BCD_MAX    = 9999;
  localparam int          ACC_W      = 16;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: a BCD digit of 5 or more gets +3
// so the following left shift carries cleanly into the next decade.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = (din >= 4'd5) ? din + 4'd3 : din;
  end

endmodule

// File: rtl/module_bin_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per cycle.
// Optional input saturation to 9999 with an ovf flag is built when BCD_SAT_EN is defined.
module module_bin_bcd
  import bcd_pkg::*;
#(
  parameter int BIN_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] bin_in,
  input  logic             start,
  output logic             busy,
  output logic             listo,
  output logic [3:0]       unidades,
  output logic [3:0]       decenas,
  output logic [3:0]       centenas,
  output logic [3:0]       millares,
  output logic             ovf
);

  localparam int SR_W = ACC_W + BIN_W;

  state_t            state;
  logic [SR_W-1:0]   sr;
  logic [SR_W-1:0]   sr_next;
  logic [ACC_W-1:0]  corrected;
  logic [3:0]        cnt;
  logic [BIN_W-1:0]  load_val;

  // The accumulator sits above the binary operand in one shift register;
  // each accumulator nibble is corrected before the whole word shifts.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (sr[BIN_W + 4*g +: 4]),
      .dout (corrected[4*g +: 4])
    );
  end

  assign sr_next = {corrected, sr[BIN_W-1:0]} << 1;
  assign busy    = (state == CONV);

`ifdef BCD_SAT_EN
  logic sat_hit;
  logic sat_pend;

  assign sat_hit  = (32'(bin_in) > BCD_MAX);
  assign load_val = sat_hit ? BIN_W'(BCD_MAX) : bin_in;

  // ovf is captured at acceptance and published together with listo
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_pend <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        sat_pend <= sat_hit;
      end
      if (state == CONV && cnt == 4'd1) begin
        ovf <= sat_pend;
      end
    end
  end
`else
  assign load_val = bin_in;
  assign ovf      = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sr       <= '0;
      cnt      <= '0;
      listo    <= 1'b0;
      unidades <= 4'd0;
      decenas  <= 4'd0;
      centenas <= 4'd0;
      millares <= 4'd0;
    end else begin
      listo <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sr    <= {{ACC_W{1'b0}}, load_val};
            cnt   <= 4'(BIN_W);
            state <= CONV;
          end
        end
        CONV: begin
          sr  <= sr_next;
          cnt <= cnt - 4'd1;
          // Digits only move on the final iteration so the display never sees partial sums
          if (cnt == 4'd1) begin
            {millares, centenas, decenas, unidades} <= sr_next[SR_W-1 -: ACC_W];
            listo <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_module_bin_bcd.sv
// Directed self-checking bench for module_bin_bcd at BIN_W=14.
// Expectations follow BCD_SAT_EN when the bench is compiled with it.
module tb_module_bin_bcd;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] bin_in = '0;
  logic        start = 1'b0;
  logic        busy, listo, ovf;
  logic [3:0]  unidades, decenas, centenas, millares;
  logic [15:0] digits;

  int vec  = 0;
  int errs = 0;

  assign digits = {millares, centenas, decenas, unidades};

  module_bin_bcd #(.BIN_W(14)) dut (
    .clk      (clk),
    .rst      (rst),
    .bin_in   (bin_in),
    .start    (start),
    .busy     (busy),
    .listo    (listo),
    .unidades (unidades),
    .decenas  (decenas),
    .centenas (centenas),
    .millares (millares),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  // Launches one conversion and waits (bounded) for listo; lat stays 0 on timeout
  task automatic run_conv(input logic [13:0] v, output int lat, output int busy_cyc,
                          output bit held);
    logic [15:0] prev;
    @(negedge clk);
    start = 1'b1;
    bin_in = v;
    prev = digits;
    lat = 0;
    busy_cyc = 0;
    held = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (listo) begin
        lat = i;
        break;
      end
      if (busy) busy_cyc++;
      if (digits !== prev) held = 1'b0;
    end
  endtask

  task automatic test_reset;
    #12;
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
    vec++; if (listo !== 1'b0) begin errs++; $display("FAIL reset_listo: got %b want 0", listo); end
    vec++; if (ovf !== 1'b0) begin errs++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    vec++; if (digits !== 16'h0000) begin errs++; $display("FAIL reset_digits: got %h want 0000", digits); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_zero;
    int lat, bc;
    bit held;
    run_conv(14'd0, lat, bc, held);
    vec++; if (lat !== 15) begin errs++; $display("FAIL zero_latency: got %0d want 15", lat); end
    vec++; if (digits !== 16'h0000) begin errs++; $display("FAIL zero_digits: got %h want 0000", digits); end
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL zero_busy_at_listo: got %b want 0", busy); end
    vec++; if (bc !== 14) begin errs++; $display("FAIL zero_busy_cycles: got %0d want 14", bc); end
  endtask

  task automatic test_1234;
    int lat, bc;
    bit held;
    run_conv(14'd1234, lat, bc, held);
    vec++; if (lat !== 15) begin errs++; $display("FAIL 1234_latency: got %0d want 15", lat); end
    vec++; if (digits !== 16'h1234) begin errs++; $display("FAIL 1234_digits: got %h want 1234", digits); end
    vec++; if (held !== 1'b1) begin errs++; $display("FAIL 1234_digits_held: got %b want 1", held); end
    @(negedge clk);
    vec++; if (listo !== 1'b0) begin errs++; $display("FAIL 1234_listo_one_cycle: got %b want 0", listo); end
    vec++; if (digits !== 16'h1234) begin errs++; $display("FAIL 1234_digits_hold_after: got %h want 1234", digits); end
  endtask

  task automatic test_overflow;
    int lat, bc;
    bit held;
    logic [15:0] exp_d;
    logic        exp_o;
    run_conv(14'd9999, lat, bc, held);
    vec++; if (lat !== 15) begin errs++; $display("FAIL 9999_latency: got %0d want 15", lat); end
    vec++; if (digits !== 16'h9999) begin errs++; $display("FAIL 9999_digits: got %h want 9999", digits); end
    vec++; if (ovf !== 1'b0) begin errs++; $display("FAIL 9999_ovf: got %b want 0", ovf); end
`ifdef BCD_SAT_EN
    exp_d = 16'h9999;
    exp_o = 1'b1;
`else
    exp_d = 16'h2345;
    exp_o = 1'b0;
`endif
    run_conv(14'd12345, lat, bc, held);
    vec++; if (lat !== 15) begin errs++; $display("FAIL 12345_latency: got %0d want 15", lat); end
    vec++; if (digits !== exp_d) begin errs++; $display("FAIL 12345_digits: got %h want %h", digits, exp_d); end
    vec++; if (ovf !== exp_o) begin errs++; $display("FAIL 12345_ovf: got %b want %b", ovf, exp_o); end
  endtask

  task automatic test_ignored_start;
    int lat;
    int pulses;
    logic [15:0] d;
    @(negedge clk);
    start = 1'b1;
    bin_in = 14'd777;
    lat = 0;
    pulses = 0;
    d = '0;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (i == 5) begin
        start = 1'b1;
        bin_in = 14'd42;
      end
      if (i == 6) start = 1'b0;
      if (listo) begin
        pulses++;
        if (lat == 0) begin
          lat = i;
          d = digits;
        end
      end
    end
    vec++; if (lat !== 15) begin errs++; $display("FAIL ignored_latency: got %0d want 15", lat); end
    vec++; if (d !== 16'h0777) begin errs++; $display("FAIL ignored_digits: got %h want 0777", d); end
    vec++; if (pulses !== 1) begin errs++; $display("FAIL ignored_pulse_count: got %0d want 1", pulses); end
    vec++; if (ovf !== 1'b0) begin errs++; $display("FAIL ignored_ovf_cleared: got %b want 0", ovf); end
  endtask

  task automatic test_back_to_back;
    int lat1, lat2;
    logic [15:0] d1, d2;
    @(negedge clk);
    start = 1'b1;
    bin_in = 14'd10;
    lat1 = 0;
    lat2 = 0;
    d1 = '0;
    d2 = '0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 1) bin_in = 14'd20;
      if (listo) begin
        if (lat1 == 0) begin
          lat1 = i;
          d1 = digits;
        end else begin
          lat2 = i;
          d2 = digits;
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    vec++; if (lat1 !== 15) begin errs++; $display("FAIL b2b_first_latency: got %0d want 15", lat1); end
    vec++; if (d1 !== 16'h0010) begin errs++; $display("FAIL b2b_first_digits: got %h want 0010", d1); end
    vec++; if (lat2 !== 30) begin errs++; $display("FAIL b2b_second_latency: got %0d want 30", lat2); end
    vec++; if (d2 !== 16'h0020) begin errs++; $display("FAIL b2b_second_digits: got %h want 0020", d2); end
    @(negedge clk);
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL b2b_no_extra_accept: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid;
    int pulses;
    int lat, bc;
    bit held;
    @(negedge clk);
    start = 1'b1;
    bin_in = 14'd5555;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
    end
    rst = 1'b1;
    #1;
    vec++; if (digits !== 16'h0000) begin errs++; $display("FAIL midrst_digits: got %h want 0000", digits); end
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL midrst_busy: got %b want 0", busy); end
    vec++; if (listo !== 1'b0) begin errs++; $display("FAIL midrst_listo: got %b want 0", listo); end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (listo) pulses++;
    end
    vec++; if (pulses !== 0) begin errs++; $display("FAIL midrst_no_listo: got %0d want 0", pulses); end
    run_conv(14'd9, lat, bc, held);
    vec++; if (lat !== 15) begin errs++; $display("FAIL after_rst_latency: got %0d want 15", lat); end
    vec++; if (digits !== 16'h0009) begin errs++; $display("FAIL after_rst_digits: got %h want 0009", digits); end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_1234();
    test_overflow();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/module_bin_bcd.md
# module_bin_bcd

Sequential binary-to-BCD converter using iterative shift-and-add-3 (double dabble). It sits directly upstream of the seven-segment display multiplexer. It takes a binary count and produces the four decimal digits (unidades, decenas, centenas, millares) plus the `listo` strobe that the display stage consumes. Digit outputs are registered and held stable between conversions, so the display never shows intermediate values.

## Interface
- `BIN_W`, default 14: width of the binary input; legal range 4..14.
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `bin_in`  in  BIN_W: binary value to convert; sampled only on an accepted `start`.
- `start`  in  1: conversion request; accepted only when `busy`=0.
- `busy`  out  1: high while a conversion is in progress.
- `listo`  out  1: one-cycle pulse; new digits are valid on the same cycle.
- `unidades`  out  4: BCD ones digit.
- `decenas`  out  4: BCD tens digit.
- `centenas`  out  4: BCD hundreds digit.
- `millares`  out  4: BCD thousands digit.
- `ovf`  out  1: the latched input exceeded 9999; driven only when saturation is compiled in (see Configuration).

## Operation
- FSM states: IDLE, CONV.
- IDLE with `start`=1:
  - latch `bin_in` into the shift register; clear the 16-bit BCD accumulator;
  - load iteration counter with BIN_W;
  - go to CONV.
- IDLE with `start`=0: stay in IDLE.
- CONV, one iteration per cycle:
  - each 4-bit accumulator nibble ≥5 gets +3;
  - then shift {accumulator, binary} left by 1;
  - decrement the counter.
- Last iteration (counter reaching 0):
  - write the corrected, shifted accumulator to the four digit output registers;
  - assert `listo` (registered) for exactly one cycle;
  - return to IDLE.
- Digit outputs change only on that final cycle. They hold the last result indefinitely otherwise.
- Width rule: the accumulator is 16 bits, so any carry beyond the thousands digit is discarded. The result is therefore value mod 10000 unless saturation applies.
- `start` while `busy`=1 is ignored. No queuing occurs, and `bin_in` changes during CONV have no effect.
- `start` on the cycle `listo`=1 is accepted, because state is IDLE by then. This makes back-to-back conversions possible.
- Reset values: state IDLE, `busy`=0, `listo`=0, `ovf`=0, all digits 0.
- Reset mid-conversion aborts immediately. No `listo` pulse follows.

## Timing
- `start` accepted at rising edge N.
- `busy`=1 during cycles N+1 .. N+BIN_W.
- Digits are valid and `listo`=1 in cycle N+BIN_W+1; `busy`=0 in that cycle.
- Latency with BIN_W=14 is 15 cycles from the accepting edge to `listo`.
- Throughput is one conversion every BIN_W+1 cycles when `start` is held high.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro: `BCD_SAT_EN`.
- Defined:
  - at `start` acceptance, a latched value >9999 is replaced by 9999 before conversion;
  - `ovf` registers 1 together with `listo` and holds until the next `listo`;
  - `ovf` registers 0 for in-range values.
- Undefined:
  - no comparator is built; `ovf` is tied 0;
  - values above 9999 yield value mod 10000.
- With BIN_W ≤13 the comparison is still built, since 8191 < 9999 means it never fires. Synthesis may remove it.

## Structure
- Package `bcd_pkg` holds:
  - the FSM state enum (IDLE, CONV);
  - localparams NUM_DIGITS=4, BCD_MAX=9999, ACC_W=16.
- Sub-module `bcd_add3`: combinational 4-bit nibble correction (out = in ≥5 ? in+3 : in). Instantiated four times.

## Test plan
- Reset release, then `bin_in`=0 with `start` pulse → after 15 cycles `listo`=1 with digits 0/0/0/0 and `busy` low.
- `bin_in`=1234 → `listo` at cycle N+15 with millares=1, centenas=2, decenas=3, unidades=4. Digits unchanged during cycles N+1..N+14 from the previous result.
- `bin_in`=9999, then 12345:
  - with `BCD_SAT_EN`: 9/9/9/9 with `ovf`=0, then 9/9/9/9 with `ovf`=1;
  - without it: 2/3/4/5 with `ovf`=0.
- Second `start` with `bin_in`=42 at cycle N+5 of a conversion of 777 → ignored; single `listo` shows 0/7/7/7.
- `start` held high with `bin_in` toggling 10, 20 at each acceptance → `listo` every 15 cycles showing 0010, then 0020.
- `rst` asserted at cycle N+7 of a conversion of 5555 → digits 0 and `busy`/`listo` 0 immediately. No `listo` appears after release until a new `start`.
